tbl_loader: RTL and testbench
=============================

Name: tbl_loader

Overview:
- Upstream fill engine for the tblD math lookup RAM (256 x 68-bit seed entries).
- Accepts a load command of base index plus entry count, then collects each 68-bit entry from a 32-bit valid/ready word stream.
- Drives the table write port: A carries the entry, B[53:46] carries the index, plus a one-cycle write strobe.
- Holds off table reads while a load is in progress.

Parameters:
- WORDS_PER_ENTRY, 3, stream words per table entry (fixed; word2 supplies bits 67:64).
- IDX_W, 8, table index width (256 entries).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle load request; sampled only in IDLE.
- cmd_base  in  8  first table index to write.
- cmd_count  in  9  number of entries, 0..256.
- cmd_abort  in  1  terminates the load at the next edge.
- in_data  in  32  stream word.
- in_valid  in  1  stream word present.
- in_ready  out  1  loader accepts in_data this cycle.
- tbl_A  out  68  entry data to the table.
- tbl_B  out  68  index in [53:46]; all other bits zero.
- tbl_is_write  out  1  table write strobe, one cycle per entry.
- busy  out  1  load in progress; the consumer must not assert is_read.
- done  out  1  one-cycle pulse at the end of a load or abort.
- err  out  1  sticky format error; cleared by the next accepted cmd_start.

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready=0; tbl_is_write=0; tbl_A=0; tbl_B=0; busy=0; done=0; err=0; all counters 0.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - cmd_start=1 with count>0 -> COLLECT. Latches idx=cmd_base and remaining=cmd_count, sets word_cnt=0, clears err.
  - cmd_start=1 with count=0 -> DONE directly. No write occurs; err is cleared.
- COLLECT:
  - in_ready=1.
  - On in_valid&in_ready:
    - word_cnt 0 stores bits 31:0.
    - word_cnt 1 stores bits 63:32.
    - word_cnt 2 stores in_data[3:0] into bits 67:64. If in_data[31:4]!=0, err is set and the entry is still written. Then -> WRITE.
  - word_cnt increments on each accept and resets to 0 on entering WRITE.
- WRITE:
  - Exactly one cycle; in_ready=0; tbl_is_write=1.
  - tbl_A = assembled entry; tbl_B[53:46] = idx.
  - At the edge: idx increments mod 256 (255 wraps to 0) and remaining decrements.
  - If remaining was 1 -> DONE, else -> COLLECT.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in COLLECT and WRITE; busy=0 in IDLE and DONE.
- Latency: the last accepted word of an entry is followed by tbl_is_write on the next cycle. Peak throughput is one entry per 4 cycles.
- tbl_A and tbl_B hold their last values outside WRITE. Only tbl_is_write qualifies them.
- cmd_abort:
  - In COLLECT or WRITE -> DONE on the next edge. A partially collected entry is discarded.
  - If it coincides with a WRITE cycle, that write still completes.
  - Abort in IDLE or DONE is ignored.
- cmd_start outside IDLE is ignored; there is no queuing.
- Count 256 with base 0x80 writes indices 0x80..0xFF, then 0x00..0x7F.
- in_valid stalls in COLLECT simply extend the state; there is no timeout.
- Reset mid-load returns to IDLE immediately. Table contents already written are not touched.

Test Plan:
- Basic load: base=0x10, count=2, stream 0x11111111, 0x22222222, 0x5, 0xAAAAAAAA, 0xBBBBBBBB, 0xC.
  - Write 1: tbl_A=68'h5_22222222_11111111, B[53:46]=0x10.
  - Write 2: tbl_A=68'hC_BBBBBBBB_AAAAAAAA, B[53:46]=0x11.
  - done pulses 1 cycle after write 2; err=0.
- Wrap: base=0xFF, count=2 -> writes at index 0xFF then 0x00; busy drops in the DONE cycle.
- Format error: word2=0x00000013 -> entry bits 67:64=0x3, written; err=1 and stays 1 until the next cmd_start.
- Zero count and ignored start: count=0 -> done 1 cycle after start, no tbl_is_write. A second cmd_start during busy is ignored: the write count matches the first command only.
- Abort: count=4, abort after the 2nd word of entry 2 -> exactly 1 write (index base); done pulses next cycle; in_ready=0 afterwards.
- Async reset and stall: assert rst=0 mid-COLLECT between clock edges -> busy, in_ready and tbl_is_write go 0 immediately. Random in_valid gaps -> entries and indices unchanged versus the no-gap run.

Source files
------------

// File: rtl/tbl_loader.sv
// rtl/tbl_loader.sv - stream-fed fill engine for the tblD 256 x 68-bit seed RAM
//
// Collects WORDS_PER_ENTRY 32-bit stream words per table entry and issues one
// write strobe per entry at consecutive (mod 256) indices from a commanded base.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   cmd_start         one-cycle load request (honoured in IDLE only)
//   cmd_base          first table index
//   cmd_count         entry count, 0..256
//   cmd_abort         end the load at the next edge
//   in_data/in_valid  stream word and its valid
//   in_ready          stream word accepted this cycle when in_valid is high
//   tbl_A             assembled 68-bit entry
//   tbl_B             index in [53:46], all other bits zero
//   tbl_is_write      one-cycle write strobe qualifying tbl_A/tbl_B
//   busy              load in progress; table reads must be held off
//   done              one-cycle pulse at the end of a load or abort
//   err               sticky format error, cleared by the next accepted start
module tbl_loader #(
    parameter int WORDS_PER_ENTRY = 3,
    parameter int IDX_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic [IDX_W-1:0] cmd_base,
    input  logic [IDX_W:0]   cmd_count,
    input  logic             cmd_abort,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [67:0]      tbl_A,
    output logic [67:0]      tbl_B,
    output logic             tbl_is_write,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   remaining;
    logic [1:0]       word_cnt;
    logic [63:0]      entry_lo;
    logic             accept;
    logic             last_word;
    logic [67:0]      b_val;

    assign last_word = (word_cnt == 2'(WORDS_PER_ENTRY - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        tbl_is_write = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_start) begin
                    state_nxt = (cmd_count != '0) ? COLLECT : DONE;
                end
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (cmd_abort) begin
                    state_nxt = DONE;
                end else if (accept && last_word) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                tbl_is_write = 1'b1;
                busy         = 1'b1;
                // The strobe is already out this cycle, so an abort here still
                // lets the current write land before stopping.
                if (cmd_abort || remaining == (IDX_W+1)'(1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = COLLECT;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        b_val                = '0;
        b_val[46 +: IDX_W]   = idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            remaining <= '0;
            word_cnt  <= '0;
            entry_lo  <= '0;
            tbl_A     <= '0;
            tbl_B     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        idx       <= cmd_base;
                        remaining <= cmd_count;
                        word_cnt  <= '0;
                        err       <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (cmd_abort) begin
                        // Partial entry is dropped; tbl_A/tbl_B keep the last write.
                        word_cnt <= '0;
                    end else if (accept) begin
                        if (last_word) begin
                            // Table outputs are loaded on entry to WRITE so they
                            // are stable for the whole strobe cycle.
                            tbl_A    <= {in_data[3:0], entry_lo};
                            tbl_B    <= b_val;
                            word_cnt <= '0;
                            if (in_data[31:4] != '0) begin
                                err <= 1'b1;
                            end
                        end else begin
                            word_cnt <= word_cnt + 2'd1;
                            if (word_cnt == 2'd0) begin
                                entry_lo[31:0] <= in_data;
                            end else begin
                                entry_lo[63:32] <= in_data;
                            end
                        end
                    end
                end
                WRITE: begin
                    idx       <= idx + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tbl_loader.sv
// tb/tb_tbl_loader.sv - directed self-checking bench for tbl_loader
module tb_tbl_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_start = 1'b0;
    logic [7:0]  cmd_base = '0;
    logic [8:0]  cmd_count = '0;
    logic        cmd_abort = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [67:0] tbl_A;
    logic [67:0] tbl_B;
    logic        tbl_is_write;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;

    logic [67:0] wr_a [0:63];
    logic [7:0]  wr_i [0:63];
    logic        wr_bok [0:63];
    int          wr_n     = 0;
    int          wr_cyc   = 0;
    int          done_cyc = 0;
    int          base_n;

    localparam logic [67:0] IDX_MASK = 68'hF_FFFF_FFFF_FFFF_FFFF & ~(68'hFF << 46);

    tbl_loader dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_start    (cmd_start),
        .cmd_base     (cmd_base),
        .cmd_count    (cmd_count),
        .cmd_abort    (cmd_abort),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tbl_A        (tbl_A),
        .tbl_B        (tbl_B),
        .tbl_is_write (tbl_is_write),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tbl_is_write && wr_n < 64) begin
            wr_a[wr_n]   = tbl_A;
            wr_i[wr_n]   = tbl_B[53:46];
            wr_bok[wr_n] = ((tbl_B & IDX_MASK) == '0);
            wr_n         = wr_n + 1;
            wr_cyc       = cyc;
        end
        if (done) done_cyc = cyc;
    end

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] b, input logic [8:0] c);
        cmd_start = 1'b1;
        cmd_base  = b;
        cmd_count = c;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        int n;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("send_timeout", 68'(n), 68'(0));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 50) begin
            step();
            n++;
        end
        check({tag, "_done"}, 68'(done), 68'(1));
        check({tag, "_busy_in_done"}, 68'(busy), 68'(0));
        step();
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_in_ready", 68'(in_ready), 68'(0));
        check("rst_is_write", 68'(tbl_is_write), 68'(0));
        check("rst_busy", 68'(busy), 68'(0));
        check("rst_done", 68'(done), 68'(0));
        check("rst_err", 68'(err), 68'(0));
        check("rst_tbl_A", tbl_A, 68'h0);
        check("rst_tbl_B", tbl_B, 68'h0);
        step();
        rst = 1'b1;
        step();

        // Basic load
        base_n = wr_n;
        start(8'h10, 9'd2);
        check("basic_busy", 68'(busy), 68'(1));
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        send_word(32'h00000005, 0);
        send_word(32'hAAAAAAAA, 0);
        send_word(32'hBBBBBBBB, 0);
        send_word(32'h0000000C, 0);
        wait_done("basic");
        check("basic_nwr", 68'(wr_n - base_n), 68'(2));
        check("basic_a0", wr_a[base_n], 68'h5_22222222_11111111);
        check("basic_i0", 68'(wr_i[base_n]), 68'h10);
        check("basic_a1", wr_a[base_n+1], 68'hC_BBBBBBBB_AAAAAAAA);
        check("basic_i1", 68'(wr_i[base_n+1]), 68'h11);
        check("basic_b_zero", 68'(wr_bok[base_n] & wr_bok[base_n+1]), 68'(1));
        check("basic_done_lat", 68'(done_cyc - wr_cyc), 68'(1));
        check("basic_err", 68'(err), 68'(0));

        // Index wrap
        base_n = wr_n;
        start(8'hFF, 9'd2);
        send_word(32'h1, 0); send_word(32'h2, 0); send_word(32'h3, 0);
        send_word(32'h4, 0); send_word(32'h5, 0); send_word(32'h6, 0);
        wait_done("wrap");
        check("wrap_nwr", 68'(wr_n - base_n), 68'(2));
        check("wrap_i0", 68'(wr_i[base_n]), 68'hFF);
        check("wrap_i1", 68'(wr_i[base_n+1]), 68'h00);
        check("wrap_a1", wr_a[base_n+1], 68'h6_00000005_00000004);

        // Format error
        base_n = wr_n;
        start(8'h40, 9'd1);
        send_word(32'h12345678, 0);
        send_word(32'h9ABCDEF0, 0);
        send_word(32'h00000013, 0);
        wait_done("fmt");
        check("fmt_nwr", 68'(wr_n - base_n), 68'(1));
        check("fmt_a0", wr_a[base_n], 68'h3_9ABCDEF0_12345678);
        step(); step();
        check("fmt_err_sticky", 68'(err), 68'(1));

        // Zero count: straight to DONE, no write, err cleared
        base_n = wr_n;
        start(8'h20, 9'd0);
        check("zero_done", 68'(done), 68'(1));
        check("zero_err_clr", 68'(err), 68'(0));
        check("zero_busy", 68'(busy), 68'(0));
        step(); step(); step();
        check("zero_nwr", 68'(wr_n - base_n), 68'(0));
        check("zero_done_gone", 68'(done), 68'(0));

        // Start while busy is ignored
        base_n = wr_n;
        start(8'h30, 9'd1);
        send_word(32'hDEADBEEF, 0);
        start(8'h50, 9'd3);
        send_word(32'hCAFEF00D, 0);
        send_word(32'h00000007, 0);
        wait_done("ign");
        step(); step();
        check("ign_nwr", 68'(wr_n - base_n), 68'(1));
        check("ign_i0", 68'(wr_i[base_n]), 68'h30);
        check("ign_a0", wr_a[base_n], 68'h7_CAFEF00D_DEADBEEF);
        check("ign_idle_busy", 68'(busy), 68'(0));
        check("ign_idle_ready", 68'(in_ready), 68'(0));

        // Abort after the 2nd word of entry 2
        base_n = wr_n;
        start(8'h60, 9'd4);
        send_word(32'h01010101, 0);
        send_word(32'h02020202, 0);
        send_word(32'h00000003, 0);
        send_word(32'h04040404, 0);
        send_word(32'h05050505, 0);
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        check("abort_done", 68'(done), 68'(1));
        check("abort_ready", 68'(in_ready), 68'(0));
        step();
        check("abort_ready_after", 68'(in_ready), 68'(0));
        check("abort_done_pulse", 68'(done), 68'(0));
        check("abort_nwr", 68'(wr_n - base_n), 68'(1));
        check("abort_i0", 68'(wr_i[base_n]), 68'h60);
        check("abort_a0", wr_a[base_n], 68'h3_02020202_01010101);

        // Asynchronous reset mid-COLLECT
        start(8'h70, 9'd2);
        send_word(32'h77777777, 0);
        #3;
        rst = 1'b0;
        #1;
        check("arst_busy", 68'(busy), 68'(0));
        check("arst_ready", 68'(in_ready), 68'(0));
        check("arst_is_write", 68'(tbl_is_write), 68'(0));
        check("arst_tbl_A", tbl_A, 68'h0);
        step();
        rst = 1'b1;
        step();

        // Basic load again with random in_valid gaps
        base_n = wr_n;
        start(8'h10, 9'd2);
        send_word(32'h11111111, int'($urandom_range(0, 3)));
        send_word(32'h22222222, int'($urandom_range(0, 3)));
        send_word(32'h00000005, int'($urandom_range(0, 3)));
        send_word(32'hAAAAAAAA, int'($urandom_range(0, 3)));
        send_word(32'hBBBBBBBB, int'($urandom_range(0, 3)));
        send_word(32'h0000000C, int'($urandom_range(0, 3)));
        wait_done("stall");
        check("stall_nwr", 68'(wr_n - base_n), 68'(2));
        check("stall_a0", wr_a[base_n], 68'h5_22222222_11111111);
        check("stall_i0", 68'(wr_i[base_n]), 68'h10);
        check("stall_a1", wr_a[base_n+1], 68'hC_BBBBBBBB_AAAAAAAA);
        check("stall_i1", 68'(wr_i[base_n+1]), 68'h11);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
